// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider, one quotient bit per clock.
// Quotient and remainder are formed in the Q and R working registers and are
// presented on the outputs directly; they hold until the next accepted start.
module seq_divider #(
   parameter int unsigned WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             dz_q, dz_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             accept;
   logic [WIDTH-1:0] r_shift;
   logic [WIDTH:0]   trial;

   // One restoring step: shift the next dividend bit into R, then trial-subtract D.
   always_comb begin
      r_shift = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
      trial   = {1'b0, r_shift} - {1'b0, d_q};
   end

   // Next-state, datapath and registered-output computation.
   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      r_d     = r_q;
      d_d     = d_q;
      cnt_d   = cnt_q;
      dz_d    = dz_q;
      accept  = 1'b0;

      case (state_q)
         S_IDLE: begin
            accept = start;
         end
         S_RUN: begin
            if (!trial[WIDTH]) begin
               r_d = trial[WIDTH-1:0];
               q_d = {q_q[WIDTH-2:0], 1'b1};
            end else begin
               r_d = r_shift;
               q_d = {q_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            accept  = start;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // New operation; a zero divisor resolves immediately without iterating.
      if (accept) begin
         d_d   = divisor;
         q_d   = dividend;
         r_d   = '0;
         cnt_d = CW'(WIDTH);
         dz_d  = 1'b0;
         if (divisor == '0) begin
            state_d = S_DONE;
            q_d     = '1;
            r_d     = dividend;
            dz_d    = 1'b1;
         end else begin
            state_d = S_RUN;
         end
      end

      busy_d = (state_d == S_RUN);
      done_d = (state_d == S_DONE);
   end

   // State and datapath registers with asynchronous clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         q_q     <= '0;
         r_q     <= '0;
         d_q     <= '0;
         cnt_q   <= '0;
         dz_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         r_q     <= r_d;
         d_q     <= d_d;
         cnt_q   <= cnt_d;
         dz_q    <= dz_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Outputs come straight from flops.
   always_comb begin
      busy        = busy_q;
      done        = done_q;
      quotient    = q_q;
      remainder   = r_q;
      div_by_zero = dz_q;
   end

endmodule

// File: doc/seq_divider.md
# seq_divider

Multi-cycle unsigned restoring divider that computes quotient and remainder one bit per clock. It is built on repeated trial subtraction, the inverse of the ripple-add datapath. It sits beside the ALU in the execute stage and serves the UDIV path. The pipeline stalls on `busy` and resumes on `done`.

## Interface
- `WIDTH`, default 64: operand, quotient and remainder width in bits. Legal values are 2 or greater.
- `clk`  input  1: single clock; all state updates on the rising edge.
- `reset`  input  1: asynchronous, active-high reset.
- `start`  input  1: request a division; sampled only when the unit accepts (IDLE or DONE).
- `dividend`  input  WIDTH: numerator; sampled with `start`.
- `divisor`  input  WIDTH: denominator; sampled with `start`.
- `busy`  output  1: high while an operation is in progress (state RUN).
- `done`  output  1: single-cycle pulse; results are valid in that cycle.
- `quotient`  output  WIDTH: result quotient; holds until the next accepted `start`.
- `remainder`  output  WIDTH: result remainder; holds until the next accepted `start`.
- `div_by_zero`  output  1: flag for the last accepted operation; holds with the results.

## Operation
- States are IDLE, RUN and DONE. In reset, state is IDLE and `busy`, `done`, `quotient`, `remainder` and `div_by_zero` are all 0.
- Accept: `start`=1 while state is IDLE or DONE.
  - The unit latches `divisor` into D.
  - It loads Q with `dividend` and clears the partial remainder R.
  - It loads the iteration counter with WIDTH and clears `div_by_zero`.
- Accept with `divisor`=0:
  - The next state is DONE directly.
  - `quotient` becomes all ones, `remainder` becomes `dividend`, and `div_by_zero` becomes 1.
- Accept with `divisor`≠0: the next state is RUN.
- Each RUN cycle performs one restoring step:
  - Shift: R' = {R[WIDTH-2:0], Q[WIDTH-1]}.
  - Trial: T = {1'b0,R'} − {1'b0,D}, computed at WIDTH+1 bits.
  - If T[WIDTH]=0 (no borrow): R ← T[WIDTH-1:0] and Q ← {Q[WIDTH-2:0],1}.
  - Otherwise: R ← R' and Q ← {Q[WIDTH-2:0],0}.
  - The counter decrements by 1.
- The transition RUN→DONE happens on the edge that performs the final step (counter = 1). `quotient` and `remainder` are driven from Q and R.
- DONE lasts exactly one cycle. The next state is IDLE, or RUN/DONE if `start` is accepted in that same cycle (back-to-back).
- `start` in RUN is ignored. Operands are not re-sampled and there is no abort.
- `busy` = (state==RUN) and `done` = (state==DONE), both decoded from registered state with no input-to-output combinational path.
- Invariant at `done` with D≠0: `quotient`·D + `remainder` = `dividend` and `remainder` < D.

## Timing
- Start edge E0 accepts. Iterations occur on edges E1…E_WIDTH.
- `busy` is high from after E0 through E_WIDTH. `done` is high in the cycle after E_WIDTH, for WIDTH cycles of latency in total.
- Divide-by-zero: `done` is high in the cycle directly after E0 (1-cycle latency), and `busy` never asserts.
- Back-to-back: with `start` held high, a new operation is accepted in every DONE cycle. Throughput is one result per WIDTH+1 cycles.
- Reset mid-RUN: asserting `reset` clears all state and outputs immediately, without waiting for an edge. The first `start` after deassertion is accepted normally.
- Operand inputs may change freely after E0 without affecting the result.

## Test plan
- WIDTH=64, 100/7: `done` exactly 64 cycles after start with `quotient`=14, `remainder`=2, `div_by_zero`=0. `busy` is high for 64 cycles.
- WIDTH=64, 5/0: `done` 1 cycle after start with `quotient`=0xFFFF_FFFF_FFFF_FFFF, `remainder`=5, `div_by_zero`=1. `busy` stays 0.
- WIDTH=64, 0xFFFF_FFFF_FFFF_FFFF/1 gives `quotient`=0xFFFF_FFFF_FFFF_FFFF, `remainder`=0. Then 3/10 gives `quotient`=0, `remainder`=3.
- WIDTH=8, 200/13 started; after 3 cycles pulse `start` with 9/3. The second request is ignored: `done` at cycle 8 gives `quotient`=15, `remainder`=5.
- WIDTH=8, start held high with 200/13 then 9/3 presented during DONE: first result 15/5, second accepted in the DONE cycle, and `done` again 9 cycles later with `quotient`=3, `remainder`=0.
- WIDTH=8, `reset` asserted 4 cycles into 200/13: `busy`, `done`, `quotient`, `remainder` and `div_by_zero` go to 0 immediately. After release, 50/7 yields `quotient`=7, `remainder`=1.
